shift_feed_ctrl: RTL and testbench
==================================

SHIFT_FEED_CTRL -- requirements
Module: shift_feed_ctrl

Interface
REQ-001 The block SHALL have parameter MSB, default 8, meaning the word width, equal to the downstream shift register width; legal values are MSB >= 2.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the input FIFO depth in words; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port in_data, input, MSB bits: the parallel word to serialise.
REQ-008 The block SHALL have port in_dir, input, 1 bit: shift direction for this word; 1 = left, 0 = right.
REQ-009 The block SHALL have port d, output, 1 bit: the serial bit to the shift register.
REQ-010 The block SHALL have port en, output, 1 bit: the shift enable to the shift register.
REQ-011 The block SHALL have port dir, output, 1 bit: the direction to the shift register.
REQ-012 The block SHALL have port circular, output, 1 bit: tied to constant 0.
REQ-013 The block SHALL have port word_done, output, 1 bit: a one-cycle pulse after the last shift of a word.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH+1) bits: the FIFO occupancy.

Function
REQ-015 A word SHALL be accepted on a rising edge when in_valid && in_ready; in_ready SHALL equal (level != DEPTH).
REQ-016 The FIFO SHALL store {in_dir, in_data}; it has no bypass, so a push into an empty FIFO is not serialised in the same cycle.
REQ-017 The FSM states SHALL be IDLE and SHIFT, plus PAR when the parity feature is compiled in.
REQ-018 In IDLE with level != 0, the FSM SHALL pop one entry, go to SHIFT, and register en=1, dir=entry dir, and d=first bit; first en-high cycle is 2 cycles after the accepting edge.
REQ-019 For dir=1 the bit order SHALL be MSB-first (in_data[MSB-1] down to [0]); for dir=0 it SHALL be LSB-first; after MSB shifts the register holds in_data unchanged.
REQ-020 SHIFT SHALL last exactly MSB cycles with en=1, counted by a bit counter of $clog2(MSB) bits that wraps to 0 at word end.
REQ-021 On the last SHIFT cycle with level != 0, the FSM SHALL pop the next entry and stay in SHIFT, so back-to-back words have no en gap; otherwise it goes to IDLE.
REQ-022 In IDLE, en SHALL be 0, while d and dir hold their last values.
REQ-023 word_done SHALL be registered and high for exactly the one cycle following each word's final en-high cycle.
REQ-024 A simultaneous push and pop SHALL leave level unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-025 When the FIFO is full, a pop SHALL raise in_ready in the next cycle only.

Reset
REQ-026 While rstn=0 at a clock edge, the block SHALL set state=IDLE, en=0, d=0, dir=0, word_done=0, level=0, the pointers to 0, and the bit counter to 0.
REQ-027 A reset mid-word or mid-FIFO SHALL discard all words, with no partial en afterwards; in_ready=1 from the first cycle after reset.

Configuration
REQ-028 The macro SHIFT_FEED_PARITY_EN SHALL control the parity feature.
REQ-029 With SHIFT_FEED_PARITY_EN defined, each word SHALL be followed by state PAR, lasting one en=1 cycle with d = even parity (XOR of in_data).
REQ-030 With SHIFT_FEED_PARITY_EN defined, word_done SHALL follow the PAR cycle, and the back-to-back pop SHALL occur in PAR.
REQ-031 Without SHIFT_FEED_PARITY_EN, there SHALL be no PAR state and no parity logic, and each word is exactly MSB en cycles.

Structure
REQ-032 The package shift_feed_pkg SHALL hold the FSM state enum and the FIFO entry struct {dir, data}.
REQ-033 The block SHALL instantiate one sub-module, shift_feed_fifo (synchronous FIFO with push, pop, full, empty, level); the FSM and serialiser SHALL stay in shift_feed_ctrl.

Verification
REQ-034 The bench SHALL cover: MSB=8, one word 8'hA5 with in_dir=1 -> d = 1,0,1,0,0,1,0,1 over 8 en cycles starting 2 cycles after accept; then word_done pulse; the downstream register holds 8'hA5.
REQ-035 The bench SHALL cover: word 8'h01 with in_dir=0 -> d = 1,0,0,0,0,0,0,0 (LSB first) with dir=0 throughout.
REQ-036 The bench SHALL cover: 6 words pushed with in_valid held high, DEPTH=4 -> in_ready drops when level=4; 48 contiguous en cycles with no gap; 6 word_done pulses.
REQ-037 The bench SHALL cover: rstn low on the 4th shift cycle with 2 words queued -> en=0, level=0 and in_ready=1 next cycle; no further en until a new push.
REQ-038 The bench SHALL cover: with SHIFT_FEED_PARITY_EN, word 8'h07 -> 9 en cycles, with the 9th d=1; without the macro, 8 en cycles.
REQ-039 The bench SHALL cover: push and pop in the same cycle at level=2 -> level stays 2, and the order of words is preserved.

Source files
------------

// File: rtl/shift_feed_pkg.sv
// Shared types for the shift-register feeder: FSM state encoding and the
// FIFO entry layout. Optional feature macro: SHIFT_FEED_PARITY_EN adds the
// PAR state (one trailing even-parity bit per word).
package shift_feed_pkg;

    // Widest word the FIFO entry can carry; the top uses the low MSB bits.
    localparam int DATA_W_MAX = 32;

`ifdef SHIFT_FEED_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    // One queued word: its shift direction and its parallel data.
    typedef struct packed {
        logic                  dir;
        logic [DATA_W_MAX-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/shift_feed_fifo.sv
// Small synchronous FIFO of shift_feed entries. The head entry is read
// combinationally so the controller can load the first bit on the pop edge.
module shift_feed_fifo
    import shift_feed_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  fifo_entry_t                  push_entry,
    input  logic                         pop,
    output fifo_entry_t                  head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    fifo_entry_t mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/shift_feed_ctrl.sv
// Serialises queued parallel words onto a downstream shift register
// (d / en / dir). Words are buffered in shift_feed_fifo and shifted out
// back-to-back with no enable gap. Optional feature macro:
// SHIFT_FEED_PARITY_EN appends one even-parity bit (PAR state) per word.
module shift_feed_ctrl
    import shift_feed_pkg::*;
#(
    parameter int MSB   = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MSB-1:0]               in_data,
    input  logic                         in_dir,
    output logic                         d,
    output logic                         en,
    output logic                         dir,
    output logic                         circular,
    output logic                         word_done,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int CW = $clog2(MSB);
    localparam logic [CW-1:0] LAST_BIT = CW'(MSB-1);

    state_t         state_q, state_d;
    logic           en_q, en_d;
    logic           d_q, d_d;
    logic           dir_q, dir_d;
    logic           word_done_q, word_done_d;
    logic [MSB-1:0] word_q, word_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           start_word;
    logic           fifo_full, fifo_empty;
    fifo_entry_t    push_entry, head;
    logic [CW-1:0]  cnt_inc, bit_idx;

    // Pack the incoming word into an entry; unused high data bits are zero.
    always_comb begin
        push_entry               = '0;
        push_entry.dir           = in_dir;
        push_entry.data[MSB-1:0] = in_data;
    end

    shift_feed_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (in_valid && in_ready),
        .push_entry (push_entry),
        .pop        (start_word),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (level)
    );

    // High data bits beyond the configured width are never serialised.
    generate
        if (MSB < DATA_W_MAX) begin : g_hi_sink
            logic unused_hi;
            assign unused_hi = ^head.data[DATA_W_MAX-1:MSB];
        end
    endgenerate

    // Index of the bit to present in the next shift cycle: MSB-first when
    // shifting left, LSB-first when shifting right.
    assign cnt_inc = cnt_q + 1'b1;
    assign bit_idx = dir_q ? (LAST_BIT - cnt_inc) : cnt_inc;

    // Next-state and registered-output logic of the serialiser FSM.
    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        d_d         = d_q;
        dir_d       = dir_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        start_word  = 1'b0;
        case (state_q)
            IDLE: begin
                start_word = !fifo_empty;
            end
            SHIFT: begin
                if (cnt_q != LAST_BIT) begin
                    cnt_d = cnt_inc;
                    en_d  = 1'b1;
                    d_d   = word_q[bit_idx];
                end else begin
                    cnt_d = '0;
`ifdef SHIFT_FEED_PARITY_EN
                    state_d = PAR;
                    en_d    = 1'b1;
                    d_d     = ^word_q;
`else
                    state_d     = IDLE;
                    word_done_d = 1'b1;
                    start_word  = !fifo_empty;
`endif
                end
            end
`ifdef SHIFT_FEED_PARITY_EN
            PAR: begin
                state_d     = IDLE;
                word_done_d = 1'b1;
                start_word  = !fifo_empty;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        // Loading a word overrides the idle decision so consecutive words abut.
        if (start_word) begin
            state_d = SHIFT;
            en_d    = 1'b1;
            cnt_d   = '0;
            dir_d   = head.dir;
            word_d  = head.data[MSB-1:0];
            d_d     = head.dir ? head.data[MSB-1] : head.data[0];
        end
    end

    // FSM state and serialiser output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            d_q         <= 1'b0;
            dir_q       <= 1'b0;
            word_done_q <= 1'b0;
            word_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            d_q         <= d_d;
            dir_q       <= dir_d;
            word_done_q <= word_done_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign d         = d_q;
    assign en        = en_q;
    assign dir       = dir_q;
    assign word_done = word_done_q;
    assign circular  = 1'b0;

endmodule

// File: tb/tb_shift_feed_ctrl.sv
// Directed bench for shift_feed_ctrl (MSB=8, DEPTH=4). Models the downstream
// shift register and logs every enabled bit. Works with or without
// SHIFT_FEED_PARITY_EN defined.
module tb_shift_feed_ctrl;

    localparam int MSB   = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);
`ifdef SHIFT_FEED_PARITY_EN
    localparam int EPW   = MSB + 1;
`else
    localparam int EPW   = MSB;
`endif

    logic           clk, rstn, in_valid, in_ready, in_dir;
    logic [MSB-1:0] in_data;
    logic           d, en, dir, circular, word_done;
    logic [LW-1:0]  level;

    shift_feed_ctrl #(.MSB(MSB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .d         (d),
        .en        (en),
        .dir       (dir),
        .circular  (circular),
        .word_done (word_done),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation log, refreshed by clear_log.
    int             cyc = 0;
    int             en_cnt, first_en, last_en, wd_cnt, wd_bad, dir1_cnt, ready_bad;
    int             last_accept;
    bit             saw_full;
    logic           prev_en;
    logic           bits [$];
    logic [MSB-1:0] sr, sr_snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        bits.delete();
        en_cnt    = 0;
        first_en  = -1;
        last_en   = -1;
        wd_cnt    = 0;
        wd_bad    = 0;
        dir1_cnt  = 0;
        ready_bad = 0;
        saw_full  = 1'b0;
        sr        = '0;
        sr_snap   = '0;
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (word_done === 1'b1) begin
            wd_cnt++;
            if (prev_en !== 1'b1 || (en_cnt % EPW) != 0) wd_bad++;
        end
        if (en === 1'b1) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
            bits.push_back(d);
            if (dir === 1'b1) dir1_cnt++;
            sr = dir ? {sr[MSB-2:0], d} : {d, sr[MSB-1:1]};
            if (en_cnt == MSB) sr_snap = sr;
        end
        if (in_ready !== (level != LW'(DEPTH))) ready_bad++;
        if (level == LW'(DEPTH) && in_ready === 1'b0) saw_full = 1'b1;
        prev_en = en;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic push_word(input logic [MSB-1:0] dat, input logic dr);
        int n;
        in_valid = 1'b1;
        in_data  = dat;
        in_dir   = dr;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        last_accept = cyc;
        in_valid = 1'b0;
        $display("push data=%h dir=%0d cyc=%0d level=%0d", dat, dr, cyc, level);
    endtask

    // Reassemble a word from the bit log starting at a given enabled bit.
    function automatic logic [MSB-1:0] word_at(input int start, input logic dr);
        logic [MSB-1:0] v;
        v = 'x;
        if (start + MSB > bits.size()) return v;
        for (int k = 0; k < MSB; k++) begin
            if (dr) v[MSB-1-k] = bits[start+k];
            else    v[k]       = bits[start+k];
        end
        return v;
    endfunction

    logic [MSB-1:0] s_data [6];
    logic           s_dir  [6];

    initial begin
        s_data = '{8'h11, 8'h2C, 8'hF0, 8'h5A, 8'h87, 8'h3E};
        s_dir  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; prev_en = 1'b0;
        clear_log();

        // Reset state
        run(2);
        check("rst_en", 32'(en), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_word_done", 32'(word_done), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("circular", 32'(circular), 32'd0);
        rstn = 1'b1;
        tick();

        // One word A5, left: MSB-first 1,0,1,0,0,1,0,1
        clear_log();
        push_word(8'hA5, 1'b1);
        check("a5_no_bypass_en", 32'(en), 32'd0);
        check("a5_level_after_accept", 32'(level), 32'd1);
        run(16);
        check("a5_first_en_latency", 32'(first_en - last_accept), 32'd1);
        check("a5_en_count", 32'(en_cnt), 32'(EPW));
        check("a5_en_contiguous", 32'(last_en - first_en + 1), 32'(en_cnt));
        check("a5_bits", 32'(word_at(0, 1'b1)), 32'h0A5);
        check("a5_downstream_reg", 32'(sr_snap), 32'h0A5);
        check("a5_dir_high", 32'(dir1_cnt), 32'(en_cnt));
        check("a5_word_done_count", 32'(wd_cnt), 32'd1);
        check("a5_word_done_place", 32'(wd_bad), 32'd0);
        check("a5_idle_en", 32'(en), 32'd0);
        check("a5_idle_dir_hold", 32'(dir), 32'd1);
`ifdef SHIFT_FEED_PARITY_EN
        check("a5_idle_d_hold", 32'(d), 32'd0);
`else
        check("a5_idle_d_hold", 32'(d), 32'd1);
`endif

        // One word 01, right: LSB-first 1,0,0,0,0,0,0,0
        clear_log();
        push_word(8'h01, 1'b0);
        run(16);
        check("w01_en_count", 32'(en_cnt), 32'(EPW));
        check("w01_first_bit", 32'(bits[0]), 32'd1);
        check("w01_bits", 32'(word_at(0, 1'b0)), 32'h001);
        check("w01_dir_low", 32'(dir1_cnt), 32'd0);
        check("w01_downstream_reg", 32'(sr_snap), 32'h001);
        check("w01_word_done_count", 32'(wd_cnt), 32'd1);

        // Six words streamed with in_valid held high
        clear_log();
        for (int i = 0; i < 6; i++) push_word(s_data[i], s_dir[i]);
        run(70);
        check("stream_en_count", 32'(en_cnt), 32'(6*EPW));
        check("stream_en_contiguous", 32'(last_en - first_en + 1), 32'(en_cnt));
        check("stream_word_done_count", 32'(wd_cnt), 32'd6);
        check("stream_word_done_place", 32'(wd_bad), 32'd0);
        check("stream_saw_full", 32'(saw_full), 32'd1);
        check("stream_ready_vs_level", 32'(ready_bad), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stream_word%0d", i), 32'(word_at(i*EPW, s_dir[i])), 32'(s_data[i]));
        end

        // Push and pop on the same edge at level 2
        clear_log();
        push_word(8'hC3, 1'b1);
        push_word(8'h96, 1'b0);
        push_word(8'h4B, 1'b1);
        check("pp_level_before", 32'(level), 32'd2);
        run(EPW - 2);
        check("pp_level_last_shift", 32'(level), 32'd2);
        check("pp_en_last_shift", 32'(en), 32'd1);
        push_word(8'h1E, 1'b0);
        check("pp_level_after", 32'(level), 32'd2);
        check("pp_en_no_gap", 32'(en), 32'd1);
        run(50);
        check("pp_word0", 32'(word_at(0, 1'b1)), 32'h0C3);
        check("pp_word1", 32'(word_at(EPW, 1'b0)), 32'h096);
        check("pp_word2", 32'(word_at(2*EPW, 1'b1)), 32'h04B);
        check("pp_word3", 32'(word_at(3*EPW, 1'b0)), 32'h01E);
        check("pp_word_done_count", 32'(wd_cnt), 32'd4);

        // Reset on the 4th shift cycle with 2 words queued
        clear_log();
        push_word(8'hFF, 1'b1);
        push_word(8'hAA, 1'b1);
        push_word(8'h55, 1'b1);
        run(2);
        check("rmid_en_before", 32'(en), 32'd1);
        check("rmid_level_before", 32'(level), 32'd2);
        check("rmid_shift_cycles", 32'(en_cnt), 32'd4);
        rstn = 1'b0;
        tick();
        check("rmid_en", 32'(en), 32'd0);
        check("rmid_level", 32'(level), 32'd0);
        check("rmid_in_ready", 32'(in_ready), 32'd1);
        check("rmid_d", 32'(d), 32'd0);
        check("rmid_word_done", 32'(word_done), 32'd0);
        rstn = 1'b1;
        clear_log();
        run(20);
        check("rmid_no_en_after", 32'(en_cnt), 32'd0);
        check("rmid_no_word_done_after", 32'(wd_cnt), 32'd0);
        push_word(8'h3C, 1'b1);
        run(16);
        check("rmid_recover_bits", 32'(word_at(0, 1'b1)), 32'h03C);
        check("rmid_recover_en_count", 32'(en_cnt), 32'(EPW));

        // Word 07: 8 en cycles, plus a 9th parity bit of 1 when compiled in
        clear_log();
        push_word(8'h07, 1'b1);
        run(16);
        check("w07_en_count", 32'(en_cnt), 32'(EPW));
        check("w07_bits", 32'(word_at(0, 1'b1)), 32'h007);
        check("w07_word_done_place", 32'(wd_bad), 32'd0);
`ifdef SHIFT_FEED_PARITY_EN
        check("w07_parity_bit", 32'(bits.size() > 8 ? bits[8] : 1'bx), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
